regfile_writeback: RTL
======================

# regfile_writeback

Writeback queue for the pipelined CPU core: accepts completed instruction results (one E-port and one M-port register write per instruction) from the execute/memory pipeline and drains them in order onto the register file's write ports (destE/valE, destM/valM). Holds up to DEPTH instructions while writeback is frozen. Exposes a per-register in-flight scoreboard so decode can stall on read-after-write hazards against its srcA/srcB read ports.

## Interface
Parameters:
- DATA_WID, 32: register data width (matches register file).
- ADDR_WID, 4: register address width; all-ones address (RNONE, 4'hF) means "no write".
- NUM_OF_REG, 16: register count.
- DEPTH, 4: queue entries; power of two, ≥2.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  result bundle offered.
- in_ready  out  1  bundle accepted at this edge when in_valid && in_ready.
- in_dstE  in  ADDR_WID  E-port destination (RNONE = none).
- in_valE  in  DATA_WID  E-port data.
- in_dstM  in  ADDR_WID  M-port destination (RNONE = none).
- in_valM  in  DATA_WID  M-port data.
- hold  in  1  freeze draining; queue retains contents.
- destE  out  ADDR_WID  to register file.
- valE  out  DATA_WID  to register file.
- destM  out  ADDR_WID  to register file.
- valM  out  DATA_WID  to register file.
- srcA  in  ADDR_WID  decode read address A.
- srcB  in  ADDR_WID  decode read address B.
- busyA  out  1  srcA has an in-flight write.
- busyB  out  1  srcB has an in-flight write.
- count  out  clog2(DEPTH)+1  occupied entries.

## Operation
- Circular FIFO, DEPTH entries of {dstE,valE,dstM,valM}; wr_ptr/rd_ptr with wrap at DEPTH.
- Push: in_valid && in_ready. in_ready = !RST && (count < DEPTH). No push when full, even if a pop happens in the same cycle.
- Pop: count != 0 && !hold. While popping, write outputs present the head entry (combinational from head). Otherwise destE = destM = RNONE and valE = valM = 0.
- Same-destination rule: on push, if in_dstE == in_dstM != RNONE, E is stored as RNONE. M wins.
- Scoreboard: pend[r] is a counter of width clog2(DEPTH)+1, one per register.
  - +1 per pushed non-RNONE destination (E, M).
  - −1 per popped non-RNONE destination.
  - Push and pop of the same register in one cycle gives a net change of 0.
- busyA = (srcA != RNONE) && pend[srcA] != 0; same for busyB. Combinational from registered counters. A bundle being pushed this cycle is not yet visible in busy.
- count: +1 on push, −1 on pop, unchanged on both or neither.

## Timing
- Reset (RST high at an edge): FIFO emptied, pointers 0, count = 0, all pend = 0.
  - Outputs during and after reset: destE = destM = RNONE, valE = valM = 0, busyA = busyB = 0, in_ready = 0 while RST is high.
  - Reset mid-operation discards queued entries without writing them.
- Latency: bundle pushed at edge k appears on destE/destM during cycle k..k+1 if the queue was empty and hold = 0. The register file writes it at edge k+1, where pend is decremented.
- Throughput: one push and one pop per cycle; steady state with hold = 0 keeps count ≤ 1.
- hold high: outputs RNONE, no pop, pushes continue until count = DEPTH.
- Full: in_ready low; bundle must be held by the producer. Wrap-around of both pointers is seamless.
- Order: entries leave strictly in push order.

## Test plan
- Reset: assert RST 2 cycles with in_valid = 1 -> in_ready = 0, destE = destM = 4'hF, count = 0, busyA = 0; no push occurs.
- Single pass: push {dstE=2, valE=0x11, dstM=F} with hold = 0.
  - Next cycle: destE = 2, valE = 0x11, destM = F, busyA(srcA=2) = 1.
  - Following cycle: busyA = 0, count = 0.
- Hold and fill: hold = 1, push 4 bundles dstE = 1..4 -> count = 4, in_ready = 0, 5th bundle not accepted.
  - Release hold: destE = 1,2,3,4 on consecutive cycles, then RNONE.
- Same destination: push dstE = dstM = 5, valE = 0xA, valM = 0xB -> output destE = F, destM = 5, valM = 0xB; pend[5] peaks at 1.
- Duplicate pending: hold = 1, push two bundles writing r7 -> pend[7] = 2, busyB(srcB=7) = 1.
  - Release: busyB stays 1 after the first pop and drops after the second.
- Wrap and reset mid-op: 10 push/pop cycles with hold toggling every 3 cycles -> write order matches push order across pointer wrap.
  - Then RST with count = 3 -> count = 0, all busy = 0, no further writes emitted.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback
// -----------------
// In-order writeback queue between the execute/memory pipeline and the
// register file. Each accepted bundle carries one E-port and one M-port
// register write. Bundles drain one per cycle onto destE/valE and
// destM/valM unless hold freezes the queue. A per-register count of
// queued writes drives busyA/busyB, so decode can stall on
// read-after-write hazards.
//
// Ports:
//   CLK, RST            clock; synchronous active-high reset
//   in_valid/in_ready   bundle handshake (push when both high)
//   in_dstE/in_valE     E-port destination/data (all-ones = no write)
//   in_dstM/in_valM     M-port destination/data (all-ones = no write)
//   hold                freeze draining; contents retained
//   destE/valE          register file E write port
//   destM/valM          register file M write port
//   srcA/srcB           decode read addresses
//   busyA/busyB         read address has a queued write
//   count               number of occupied entries
module regfile_writeback #(
    parameter int DATA_WID   = 32,
    parameter int ADDR_WID   = 4,
    parameter int NUM_OF_REG = 16,
    parameter int DEPTH      = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDR_WID-1:0]    in_dstE,
    input  logic [DATA_WID-1:0]    in_valE,
    input  logic [ADDR_WID-1:0]    in_dstM,
    input  logic [DATA_WID-1:0]    in_valM,
    input  logic                   hold,
    output logic [ADDR_WID-1:0]    destE,
    output logic [DATA_WID-1:0]    valE,
    output logic [ADDR_WID-1:0]    destM,
    output logic [DATA_WID-1:0]    valM,
    input  logic [ADDR_WID-1:0]    srcA,
    input  logic [ADDR_WID-1:0]    srcB,
    output logic                   busyA,
    output logic                   busyB,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_WID = $clog2(DEPTH);
    localparam int CNT_WID = PTR_WID + 1;
    localparam logic [ADDR_WID-1:0] RNONE = '1;

    logic [ADDR_WID-1:0] mem_dst_e [DEPTH];
    logic [DATA_WID-1:0] mem_val_e [DEPTH];
    logic [ADDR_WID-1:0] mem_dst_m [DEPTH];
    logic [DATA_WID-1:0] mem_val_m [DEPTH];

    logic [PTR_WID-1:0]  wr_ptr;
    logic [PTR_WID-1:0]  rd_ptr;
    logic [CNT_WID-1:0]  pend [NUM_OF_REG];
    logic [NUM_OF_REG-1:0] pend_inc;
    logic [NUM_OF_REG-1:0] pend_dec;

    logic                push;
    logic                pop;
    logic [ADDR_WID-1:0] store_dst_e;

    // A full queue refuses a push even if it also pops this cycle.
    assign in_ready = !RST && (count < CNT_WID'(DEPTH));
    assign push     = in_valid && in_ready;
    // Reset gates the pop, so no write leaks out while RST is high.
    assign pop      = !RST && (count != '0) && !hold;

    // When both ports target the same register the M write wins, so the
    // E write is dropped at entry and never counted as pending.
    assign store_dst_e = (in_dstE == in_dstM) ? RNONE : in_dstE;

    always_comb begin
        destE = RNONE;
        valE  = '0;
        destM = RNONE;
        valM  = '0;
        if (pop) begin
            destE = mem_dst_e[rd_ptr];
            valE  = mem_val_e[rd_ptr];
            destM = mem_dst_m[rd_ptr];
            valM  = mem_val_m[rd_ptr];
        end
    end

    // Entry storage needs no reset; validity is tracked by count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_dst_e[wr_ptr] <= store_dst_e;
            mem_val_e[wr_ptr] <= in_valE;
            mem_dst_m[wr_ptr] <= in_dstM;
            mem_val_m[wr_ptr] <= in_valM;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WID'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WID'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_WID'(1);
                2'b01:   count <= count - CNT_WID'(1);
                default: count <= count;
            endcase
        end
    end

    // Per-register increment/decrement requests. A stored entry never has
    // both ports on the same register, so each side contributes at most one.
    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        for (int r = 0; r < NUM_OF_REG; r++) begin
            if (ADDR_WID'(r) != RNONE) begin
                pend_inc[r] = push && ((store_dst_e == ADDR_WID'(r)) ||
                                       (in_dstM == ADDR_WID'(r)));
                pend_dec[r] = pop && ((destE == ADDR_WID'(r)) ||
                                      (destM == ADDR_WID'(r)));
            end
        end
    end

    // Simultaneous push and pop of the same register cancel out.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_OF_REG; r++) begin
                pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_OF_REG; r++) begin
                if (pend_inc[r] && !pend_dec[r]) begin
                    pend[r] <= pend[r] + CNT_WID'(1);
                end else if (pend_dec[r] && !pend_inc[r]) begin
                    pend[r] <= pend[r] - CNT_WID'(1);
                end
            end
        end
    end

    // Busy looks only at registered counts, so a bundle pushed this cycle
    // is not yet visible.
    always_comb begin
        busyA = 1'b0;
        busyB = 1'b0;
        for (int r = 0; r < NUM_OF_REG; r++) begin
            if (!RST && (ADDR_WID'(r) != RNONE) && (pend[r] != '0)) begin
                if (srcA == ADDR_WID'(r)) begin
                    busyA = 1'b1;
                end
                if (srcB == ADDR_WID'(r)) begin
                    busyB = 1'b1;
                end
            end
        end
    end

endmodule
